// File: rtl/mdu_defs.sv
// Shared definitions for the sequential multiply/divide unit: opcode
// encodings, control FSM states and datapath step modes.
package mdu_defs;

   localparam int MDU_OP_WIDTH = 3;

   localparam logic [MDU_OP_WIDTH-1:0] MDU_MUL    = 3'd0;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_MULH   = 3'd1;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHSU = 3'd2;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHU  = 3'd3;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_DIV    = 3'd4;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_DIVU   = 3'd5;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_REM    = 3'd6;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_REMU   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } mdu_state_e;

   typedef enum logic {
      MODE_MUL = 1'b0,
      MODE_DIV = 1'b1
   } mdu_mode_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// One iteration of the shift-add multiplier / restoring divider.
// Multiply: acc = {partial_hi, multiplier}; add operand when the multiplier
// LSB is set, then shift the whole accumulator right by one.
// Divide:   acc = {remainder, dividend}; shift left by one and subtract the
// divisor from the upper half, keeping the difference if it did not borrow.
module muldiv_iter_core
   import mdu_defs::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               mode,
   input  logic [WIDTH-1:0]   opa_i,
   input  logic [2*WIDTH-1:0] acc_i,
   output logic [2*WIDTH-1:0] acc_o
);

   logic [WIDTH:0] sum_s;
   logic [WIDTH:0] trial_s;

   // Compute the next accumulator value for the selected mode
   always_comb begin
      sum_s   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opa_i};
      trial_s = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, opa_i};
      acc_o   = acc_i;
      if (mode == MODE_DIV) begin
         if (trial_s[WIDTH]) begin
            acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
         end else begin
            acc_o = {trial_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
         end
      end else begin
         if (acc_i[0]) begin
            acc_o = {sum_s, acc_i[WIDTH-1:1]};
         end else begin
            acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
         end
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit. Operands are reduced to magnitudes
// at accept, iterated one bit per cycle, then sign-corrected. Divide by zero
// and signed overflow are resolved at accept without iterating.
module muldiv_seq
   import mdu_defs::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [MDU_OP_WIDTH-1:0] in_op,
   input  logic [WIDTH-1:0]        in_src1,
   input  logic [WIDTH-1:0]        in_src2,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_res
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

   mdu_state_e              state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]      acc_q, acc_d;
   logic [WIDTH-1:0]        opb_q, opb_d;
   logic [MDU_OP_WIDTH-1:0] op_q, op_d;
   logic                    negq_q, negq_d;
   logic                    negr_q, negr_d;
   logic [WIDTH-1:0]        res_q, res_d;

   logic                    sgn1_s, sgn2_s, neg1_s, neg2_s;
   logic [WIDTH-1:0]        mag1_s, mag2_s;
   logic                    div_zero_s, ovf_s, special_s;
   logic [WIDTH-1:0]        spec_res_s;
   mdu_mode_e               mode_s;
   logic [2*WIDTH-1:0]      acc_step_s, prod_s;
   logic [WIDTH-1:0]        quo_s, rem_s, final_s;

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign out_res   = res_q;
   assign mode_s    = op_q[2] ? MODE_DIV : MODE_MUL;

   muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
      .mode  (mode_s),
      .opa_i (opb_q),
      .acc_i (acc_q),
      .acc_o (acc_step_s)
   );

   // Decode operand signedness, magnitudes and the special cases at the input
   always_comb begin
      sgn1_s = 1'b0;
      sgn2_s = 1'b0;
      case (in_op)
         MDU_MULH, MDU_DIV, MDU_REM: begin
            sgn1_s = 1'b1;
            sgn2_s = 1'b1;
         end
         MDU_MULHSU: sgn1_s = 1'b1;
         default: begin
            sgn1_s = 1'b0;
            sgn2_s = 1'b0;
         end
      endcase
      neg1_s     = sgn1_s & in_src1[WIDTH-1];
      neg2_s     = sgn2_s & in_src2[WIDTH-1];
      mag1_s     = neg1_s ? -in_src1 : in_src1;
      mag2_s     = neg2_s ? -in_src2 : in_src2;
      div_zero_s = in_op[2] & (in_src2 == '0);
      ovf_s      = ((in_op == MDU_DIV) | (in_op == MDU_REM)) &
                   (in_src1 == MIN_NEG) & (in_src2 == '1);
      special_s  = div_zero_s | ovf_s;
      if (div_zero_s) begin
         spec_res_s = in_op[1] ? in_src1 : '1;
      end else if (ovf_s) begin
         spec_res_s = in_op[1] ? '0 : in_src1;
      end else begin
         spec_res_s = '0;
      end
   end

   // Sign-correct and select the result from the final iteration step
   always_comb begin
      prod_s = negq_q ? -acc_step_s : acc_step_s;
      quo_s  = acc_step_s[WIDTH-1:0];
      rem_s  = acc_step_s[2*WIDTH-1:WIDTH];
      if (op_q[2]) begin
         if (op_q[1]) begin
            final_s = negr_q ? -rem_s : rem_s;
         end else begin
            final_s = negq_q ? -quo_s : quo_s;
         end
      end else if (op_q == MDU_MUL) begin
         final_s = prod_s[WIDTH-1:0];
      end else begin
         final_s = prod_s[2*WIDTH-1:WIDTH];
      end
   end

   // Control FSM next-state and datapath register updates
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
      op_d    = op_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      res_d   = res_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  op_d   = in_op;
                  cnt_d  = '0;
                  negq_d = neg1_s ^ neg2_s;
                  negr_d = neg1_s;
                  if (in_op[2]) begin
                     acc_d = {{WIDTH{1'b0}}, mag1_s};
                     opb_d = mag2_s;
                  end else begin
                     acc_d = {{WIDTH{1'b0}}, mag2_s};
                     opb_d = mag1_s;
                  end
                  if (special_s) begin
                     res_d   = spec_res_s;
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_CALC;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_CALC: begin
               acc_d = acc_step_s;
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  res_d   = final_s;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_CALC;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DONE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opb_q   <= '0;
         op_q    <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opb_q   <= opb_d;
         op_q    <= op_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         res_q   <= res_d;
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: a reference model pushes expected
// results into a scoreboard queue at accept; results are popped and compared
// when the unit presents them.
module tb_muldiv_seq;
   import mdu_defs::*;

   localparam int W = 32;
   localparam logic [W-1:0] MINN = 32'h8000_0000;

   logic         clk = 1'b0;
   logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [2:0]   in_op;
   logic [W-1:0] in_src1, in_src2, out_res;

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [W-1:0] exp_q[$];

   always #5 clk = ~clk;

   muldiv_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_src1   (in_src1),
      .in_src2   (in_src2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res)
   );

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic is_special(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      return (op[2] && b == '0) || ((op == MDU_DIV || op == MDU_REM) && a == MINN && b == '1);
   endfunction

   function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] sa, ua, sb, ub, p;
      logic [W-1:0]   r;
      sa = {{W{a[W-1]}}, a};
      ua = {{W{1'b0}}, a};
      sb = {{W{b[W-1]}}, b};
      ub = {{W{1'b0}}, b};
      r  = '0;
      case (op)
         MDU_MUL:    begin p = ua * ub; r = p[W-1:0];   end
         MDU_MULH:   begin p = sa * sb; r = p[2*W-1:W]; end
         MDU_MULHSU: begin p = sa * ub; r = p[2*W-1:W]; end
         MDU_MULHU:  begin p = ua * ub; r = p[2*W-1:W]; end
         MDU_DIV:  r = (b == '0) ? '1 : (a == MINN && b == '1) ? a : W'($signed(a) / $signed(b));
         MDU_DIVU: r = (b == '0) ? '1 : a / b;
         MDU_REM:  r = (b == '0) ? a : (a == MINN && b == '1) ? '0 : W'($signed(a) % $signed(b));
         MDU_REMU: r = (b == '0) ? a : a % b;
         default:  r = '0;
      endcase
      return r;
   endfunction

   // Issue one request, check latency/handshake, hold the result for 'hold' cycles, then take it
   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
      int lat;
      int busy_ready;
      int exp_lat;
      logic [W-1:0] exp_r;
      exp_lat    = is_special(op, a, b) ? 1 : W + 1;
      busy_ready = 0;
      chk("in_ready_before_accept", W'(in_ready), 32'd1);
      in_valid  = 1'b1;
      in_op     = op;
      in_src1   = a;
      in_src2   = b;
      out_ready = 1'b0;
      exp_q.push_back(model(op, a, b));
      tick();
      in_valid = 1'b0;
      in_op    = 3'($urandom_range(0, 7));
      in_src1  = $urandom;
      in_src2  = $urandom;
      lat      = 1;
      while (!out_valid && lat < 100) begin
         if (in_ready) busy_ready++;
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         lat++;
      end
      chk("in_ready_low_while_busy", W'(busy_ready), 32'd0);
      chk("latency", W'(lat), W'(exp_lat));
      if (!out_valid) begin
         chk("timeout_out_valid", W'(out_valid), 32'd1);
         void'(exp_q.pop_front());
         return;
      end
      for (int i = 0; i < hold; i++) begin
         chk("hold_out_valid", W'(out_valid), 32'd1);
         chk("hold_out_res", out_res, exp_q[0]);
         chk("hold_in_ready", W'(in_ready), 32'd0);
         tick();
      end
      exp_r = exp_q.pop_front();
      chk("result", out_res, exp_r);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("idle_after_take_valid", W'(out_valid), 32'd0);
   endtask

   initial begin
      int seen;
      logic [2:0]   rop;
      logic [W-1:0] ra, rb;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_op = 3'd0; in_src1 = '0; in_src2 = '0;
      tick();
      tick();
      chk("reset_in_ready", W'(in_ready), 32'd1);
      chk("reset_out_valid", W'(out_valid), 32'd0);
      chk("reset_out_res", out_res, 32'd0);
      rst = 1'b0;

      // Directed operations from the plan
      run_op(MDU_MUL,    32'd7,          32'hFFFF_FFFD, 0);
      run_op(MDU_MULH,   MINN,           MINN,          0);
      run_op(MDU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
      run_op(MDU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
      run_op(MDU_DIV,    32'hFFFF_FFF9,  32'd2,         0);
      run_op(MDU_REM,    32'hFFFF_FFF9,  32'd2,         0);
      run_op(MDU_DIVU,   32'd100,        32'd7,         0);
      run_op(MDU_REMU,   32'd100,        32'd7,         0);
      run_op(MDU_DIVU,   32'd5,          32'd0,         0);
      run_op(MDU_REM,    32'd5,          32'd0,         0);
      run_op(MDU_DIV,    MINN,           32'hFFFF_FFFF, 0);
      run_op(MDU_REM,    MINN,           32'hFFFF_FFFF, 0);

      // Backpressure, then an immediate back-to-back request
      run_op(MDU_DIVU,   32'd1000,       32'd3,         10);
      run_op(MDU_MULH,   32'hFFFF_FFF0,  32'd9,         0);

      // Random mix including zero divisors and overflow operands
      for (int i = 0; i < 16; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = (i % 4 == 0) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom);
         if (i % 5 == 1) begin
            ra  = MINN;
            rb  = 32'hFFFF_FFFF;
            rop = (i % 2 == 0) ? MDU_DIV : MDU_REM;
         end
         run_op(rop, ra, rb, i % 3);
      end

      // Flush at CALC cycle 5 with a competing request
      in_valid = 1'b1; in_op = MDU_MUL; in_src1 = 32'd3; in_src2 = 32'd5;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      flush = 1'b1; in_valid = 1'b1; in_op = MDU_DIVU; in_src1 = 32'd5; in_src2 = 32'd0;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_calc_out_valid", W'(out_valid), 32'd0);
      chk("flush_calc_in_ready", W'(in_ready), 32'd1);
      seen = 0;
      repeat (40) begin
         tick();
         if (out_valid) seen++;
      end
      chk("flush_no_late_result", W'(seen), 32'd0);

      // Flush an untaken result in DONE
      in_valid = 1'b1; in_op = MDU_DIVU; in_src1 = 32'd5; in_src2 = 32'd0;
      tick();
      in_valid = 1'b0;
      chk("done_before_flush", W'(out_valid), 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_done_out_valid", W'(out_valid), 32'd0);
      chk("flush_done_in_ready", W'(in_ready), 32'd1);

      // Reset in the middle of an iteration
      in_valid = 1'b1; in_op = MDU_MULHU; in_src1 = 32'hFFFF_FFFF; in_src2 = 32'hFFFF_FFFF;
      tick();
      in_valid = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      tick();
      chk("rst_mid_out_valid", W'(out_valid), 32'd0);
      chk("rst_mid_in_ready", W'(in_ready), 32'd1);
      chk("rst_mid_out_res", out_res, 32'd0);
      rst = 1'b0;
      run_op(MDU_REMU, 32'd12345, 32'd100, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle, parametrised arithmetic unit that extends the single-cycle integer ALU with RV32M multiply, divide and remainder operations.
- Sits beside the ALU in the execute stage. The core stalls on a valid/ready handshake while this unit iterates.
- Computation is shift-add / restoring-divide at one bit per cycle. Divide-by-zero and signed overflow are detected early and bypass the iteration.

Parameters:
- WIDTH, 32, operand/result width in bits (≥ 4, even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not to be overridden).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  abort the in-flight operation (pipeline kill).
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- in_op  input  3  MDU_MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- in_src1  input  WIDTH  rs1 operand.
- in_src2  input  WIDTH  rs2 operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_res  output  WIDTH  result.

Behaviour:
- Interface (decided): one clock, clk; reset rst, synchronous, active-high. All state changes on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1 (combinational from IDLE), out_valid=0, out_res=0, counter=0, internal accumulators=0.
- FSM states: IDLE, CALC, DONE.
  - IDLE→CALC on accept (in_valid & in_ready) when no special case applies.
  - IDLE→DONE on accept for a special case.
  - CALC→DONE when counter reaches WIDTH.
  - DONE→IDLE on out_ready.
- in_ready = (state==IDLE). out_valid = (state==DONE). out_res is registered and stable while out_valid is high.
- Latency:
  - Accept at cycle T → CALC during T+1..T+WIDTH → out_valid at T+WIDTH+1.
  - Special cases → out_valid at T+1.
  - Back-to-back: a new accept is possible in the cycle after the out_valid/out_ready handshake; no same-cycle pass-through.
- Operand capture at accept:
  - Signed ops convert operands to magnitude and record result-sign flags.
  - MULHSU: src1 is signed, src2 is unsigned.
- Multiply: 2*WIDTH-bit product built by shift-add, then sign-corrected.
  - MUL returns the low WIDTH bits.
  - MULH, MULHSU and MULHU return the high WIDTH bits.
- Divide: restoring, one quotient bit per cycle.
  - Quotient sign = sign1 ^ sign2.
  - Remainder sign = sign of dividend.
- Special cases (resolved at accept, no iteration):
  - Divisor==0: DIV/DIVU → all ones; REM/REMU → src1.
  - Signed overflow (src1 = 1<<(WIDTH-1), src2 = all ones): DIV → src1; REM → 0.
- flush:
  - Forces state=IDLE and out_valid=0 on the next edge from any state, including DONE with an un-taken result.
  - flush has priority over accept; an in_valid asserted in the same cycle is not accepted.
- rst has priority over flush. rst mid-operation discards the operation and all outputs return to their reset values.
- out_ready while in IDLE/CALC is ignored.
- in_op/in_src changes while not in IDLE are ignored.

Decomposition:
- Shared package/header `mdu_defs`: MDU_OP_WIDTH=3, the eight opcode constants, FSM state encodings.
- One natural sub-module: `muldiv_iter_core`, the per-cycle shift-add/subtract datapath step (operands, accumulator, mode in → next accumulator out).
- Control FSM, sign handling and special-case detection stay in muldiv_seq.

Test Plan:
- MUL 7 × −3 (WIDTH=32) → out_res=0xFFFFFFEB. out_valid exactly 33 cycles after accept. in_ready low throughout.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD. REM −7 / 2 → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIVU 5 / 0 → 0xFFFFFFFF, and REM 5 / 0 → 5, both valid at T+1. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, and REM of the same operands → 0, both at T+1.
- Backpressure: hold out_ready=0 for 10 cycles after done → out_valid and out_res stay stable, in_ready=0. Then out_ready=1 → IDLE next cycle, and the next request is accepted.
- Assert flush at CALC cycle 5, with in_valid high in the same cycle → IDLE next cycle, no out_valid, request not accepted. Assert rst mid-CALC → all outputs at reset values next cycle.
